// File: rtl/ysyx_25030093_csr_file.sv
// Machine-mode CSR file: combinational reads, edge-committed writes, ecall/mret
// trap bookkeeping and a free-running 64-bit mcycle counter.
module ysyx_25030093_csr_file #(
    parameter logic [31:0] MARCHID   = 32'h0188_5A9D,
    parameter logic [31:0] MVENDORID = 32'h7973_7978
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] csr_addr,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    input  logic        csr_wen,
    input  logic [31:0] csr_wdata,
    input  logic        ecall,
    input  logic        mret,
    input  logic [31:0] pc,
    output logic [31:0] trap_vec,
    output logic [31:0] epc
);

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
    localparam logic [11:0] ADDR_MARCHID   = 12'hF12;

    logic        mie;
    logic        mpie;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [63:0] mcycle;
    logic [31:0] mstatus;
    logic        csr_commit;
    logic        wr_cycle_lo;
    logic        wr_cycle_hi;

    // Only MIE/MPIE are stored; MPP reads as machine mode, everything else zero.
    assign mstatus = {19'b0, 2'b11, 3'b0, mpie, 3'b0, mie, 3'b0};

    assign trap_vec = mtvec;
    assign epc      = mepc;

    // A trap event in the same cycle steals the write port entirely.
    assign csr_commit  = csr_wen && !ecall && !mret;
    assign wr_cycle_lo = csr_commit && (csr_addr == ADDR_MCYCLE);
    assign wr_cycle_hi = csr_commit && (csr_addr == ADDR_MCYCLEH);

    always_comb begin
        csr_rdata   = 32'h0;
        csr_illegal = 1'b0;
        case (csr_addr)
            ADDR_MSTATUS:   csr_rdata = mstatus;
            ADDR_MTVEC:     csr_rdata = mtvec;
            ADDR_MEPC:      csr_rdata = mepc;
            ADDR_MCAUSE:    csr_rdata = mcause;
            ADDR_MCYCLE:    csr_rdata = mcycle[31:0];
            ADDR_MCYCLEH:   csr_rdata = mcycle[63:32];
            ADDR_MVENDORID: csr_rdata = MVENDORID;
            ADDR_MARCHID:   csr_rdata = MARCHID;
            default:        csr_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mie    <= 1'b0;
            mpie   <= 1'b0;
            mtvec  <= 32'h0;
            mepc   <= 32'h0;
            mcause <= 32'h0;
        end else if (ecall) begin
            mepc   <= pc & 32'hFFFF_FFFC;
            mcause <= 32'd11;
            mpie   <= mie;
            mie    <= 1'b0;
        end else if (mret) begin
            mie    <= mpie;
            mpie   <= 1'b1;
        end else if (csr_wen) begin
            case (csr_addr)
                ADDR_MSTATUS: begin
                    mie  <= csr_wdata[3];
                    mpie <= csr_wdata[7];
                end
                ADDR_MTVEC:  mtvec  <= csr_wdata & 32'hFFFF_FFFC;
                ADDR_MEPC:   mepc   <= csr_wdata & 32'hFFFF_FFFC;
                ADDR_MCAUSE: mcause <= csr_wdata;
                default: ;
            endcase
        end
    end

    // A committed write to either half replaces that half and skips this cycle's tick.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mcycle <= 64'h0;
        end else if (wr_cycle_lo) begin
            mcycle <= {mcycle[63:32], csr_wdata};
        end else if (wr_cycle_hi) begin
            mcycle <= {csr_wdata, mcycle[31:0]};
        end else begin
            mcycle <= mcycle + 64'd1;
        end
    end

endmodule
